// File: rtl/mult_div_32_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state codes,
// iteration count, and the per-operation context latched at launch.
package mult_div_32_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // neg_res: negate product/quotient; neg_rem: remainder takes the dividend sign
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
  } md_ctx_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_step_32.sv
// One combinational iteration: shift-add multiply step or restoring
// shift-subtract divide step on the {hi,lo} working register.
module md_step_32
  import mult_div_32_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // Two guard bits: carry for multiply, sign of (2r - d) for divide
  logic [WIDTH+1:0] add_x, add_y, add_s;
  logic             add_ci;
  logic             sub_ok;

  always_comb begin
    if (div_i) begin
      add_x  = {1'b0, hi_i, lo_i[WIDTH-1]};
      add_y  = ~{2'b00, opnd_i};
      add_ci = 1'b1;
    end else begin
      add_x  = {2'b00, hi_i};
      add_y  = lo_i[0] ? {2'b00, opnd_i} : '0;
      add_ci = 1'b0;
    end
  end

  assign add_s  = add_x + add_y + {{(WIDTH+1){1'b0}}, add_ci};
  assign sub_ok = ~add_s[WIDTH+1];

  always_comb begin
    if (div_i) begin
      hi_o = sub_ok ? add_s[WIDTH-1:0] : {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
      lo_o = {lo_i[WIDTH-2:0], sub_ok};
    end else begin
      hi_o = add_s[WIDTH:1];
      lo_o = {add_s[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_32.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Operates on magnitudes for ITERS cycles, then applies sign correction in FIX.
module mult_div_32
  import mult_div_32_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = MD_ITERS
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_hi_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o
);

  localparam int CW = $clog2(ITERS);

  logic [1:0]       state_q, state_d;
  md_ctx_t          ctx_q, ctx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div0_q, div0_d;

  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign sgn   = op_is_signed(op_i);
  assign abs_a = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;

  md_step_32 #(.WIDTH(WIDTH)) u_step (
    .div_i  (ctx_q.is_div),
    .opnd_i (opnd_q),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Divide by zero leaves |a| in the remainder, so rem_fix restores a itself
  assign prod_fix = ctx_q.neg_res ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quo_fix  = div0_q ? '1 : (ctx_q.neg_res ? -acc_lo_q : acc_lo_q);
  assign rem_fix  = ctx_q.neg_rem ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    ctx_d    = ctx_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    div0_d   = div0_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d       = S_RUN;
          cnt_d         = '0;
          ctx_d.is_div  = op_is_div(op_i);
          ctx_d.neg_res = sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          ctx_d.neg_rem = sgn & a_i[WIDTH-1];
          div0_d        = op_is_div(op_i) & (b_i == '0);
          acc_hi_d      = '0;
          opnd_d        = op_is_div(op_i) ? abs_b : abs_a;
          acc_lo_d      = op_is_div(op_i) ? abs_a : abs_b;
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS-1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == S_FIX) begin
      if (ctx_q.is_div) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        {hi_d, lo_d} = prod_fix;
      end
    end else if (!busy_o) begin
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      ctx_q    <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctx_q    <= ctx_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div0_q   <= div0_d;
    end
  end

  assign busy_o   = (state_q == S_RUN) || (state_q == S_FIX);
  assign done_o   = (state_q == S_DONE);
  assign div0_o   = div0_q;
  assign result_o = rd_hi_i ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_32.sv
// Randomized self-checking bench for mult_div_32 against an arithmetic reference model.
module tb_mult_div_32;
  import mult_div_32_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0, rd_hi = 1'b0;
  logic [31:0] result;
  logic        busy, done, div0;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mult_div_32 dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata), .rd_hi_i(rd_hi),
    .result_o(result), .busy_o(busy), .done_o(done), .div0_o(div0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Expected {HI,LO} straight from the arithmetic definition of each op
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint px, py;
    int sx, sy, q, r;
    case (o)
      OP_MULT: begin px = $signed(x); py = $signed(y); return px * py; end
      OP_MULTU: return {32'h0, x} * {32'h0, y};
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sx = $signed(x); sy = $signed(y);
        q = sx / sy; r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    rd_hi = 1'b1; #1 h = result;
    rd_hi = 1'b0; #1 l = result;
  endtask

  // ign_at/we_at: edge index (after launch) at which a stray start / hi_we is presented
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int ign_at, input int we_at, input bit we_with_start);
    logic [63:0] exp;
    logic [31:0] h, l;
    int n;
    exp = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (we_with_start) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = x ^ 32'h5A5A_5A5A;
      m_hi = wdata; m_lo = wdata;
    end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_e0", busy, 1);
    chk("div0_launch", div0, (o[1] && y == 0));
    n = 0;
    while (!done && n < 40) begin
      if (n == ign_at - 1) begin start = 1'b1; op = OP_DIVU; a = $urandom; b = $urandom; end
      if (n == we_at - 1) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      if (n == 5) begin read_hilo(h, l); chk("hold_prev", {h, l}, {m_hi, m_lo}); end
      @(posedge clk); n++;
      @(negedge clk); start = 1'b0; hi_we = 1'b0;
      if (n == 32) chk("busy_e32", busy, 1);
    end
    chk("latency", n, 33);
    chk("busy_at_done", busy, 0);
    read_hilo(h, l);
    chk("hilo", {h, l}, exp);
    m_hi = exp[63:32]; m_lo = exp[31:0];
    chk("div0", div0, (o[1] && y == 0));
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    logic [31:0] h, l, x, y;
    logic [1:0]  o;
    int seen;

    repeat (2) @(negedge clk);
    read_hilo(h, l);
    chk("rst_hilo", {h, l}, 64'h0);
    chk("rst_flags", {busy, done, div0}, 3'b000);
    rst_n = 1'b1;

    // MTHI / MTLO in idle, separately and together
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge clk); lo_we = 1'b0;
    read_hilo(h, l);
    chk("mt_sep", {h, l}, 64'h1234_5678_9ABC_DEF0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    read_hilo(h, l);
    chk("mt_both", {h, l}, 64'h0BAD_F00D_0BAD_F00D);
    m_hi = 32'h0BAD_F00D; m_lo = 32'h0BAD_F00D;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, 0, 0, 0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(OP_DIVU,  32'd100, 32'd0, 0, 0, 0);
    run_op(OP_MULTU, 32'd2, 32'd3, 0, 0, 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0, 0, 0, 0);
    run_op(OP_MULTU, 32'd3, 32'd5, 10, 12, 0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, 1);

    // Reset in the middle of a DIVU aborts it with no result
    @(negedge clk); start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
    @(negedge clk); start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    read_hilo(h, l);
    chk("abort_hilo", {h, l}, 64'h0);
    chk("abort_flags", {busy, done, div0}, 3'b000);
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen++; end
    chk("abort_quiet", seen, 0);
    run_op(OP_DIVU, 32'd9, 32'd2, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
      run_op(o, x, y, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
